// File: rtl/ctrl_fsm_pkg.sv
// ctrl_fsm_pkg: opcodes, FSM states and instruction field positions for ctrl_fsm
package ctrl_fsm_pkg;
  typedef enum logic [2:0] {ST_FETCH, ST_DECODE, ST_EXECUTE, ST_WRITEBACK, ST_HALT} state_t;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SLT  = 3'd4;
  localparam logic [2:0] OP_LI   = 3'd5;
  localparam logic [2:0] OP_BNZ  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;
  localparam int OPC_LSB = 6;
  localparam int RD_LSB  = 4;
  localparam int RS_LSB  = 2;
  localparam int RT_LSB  = 0;
  localparam int IMM_LSB = 0;
  function automatic logic [8:0] sext9(input logic [3:0] v);
    return {{5{v[3]}}, v};
  endfunction
endpackage

// File: rtl/ctrl_fsm_instr_decode.sv
// ctrl_fsm_instr_decode: combinational IR decode into register-file fields and next-state class
module ctrl_fsm_instr_decode
  import ctrl_fsm_pkg::*;
(
  input  logic [8:0] ir,
  output logic [1:0] rd0_addr,
  output logic [1:0] rd1_addr,
  output logic [1:0] wr_addr,
  output logic [2:0] alu_op,
  output logic [8:0] imm_data,
  output logic       wb_sel,
  output state_t     next_state
);
  logic [2:0] opcode;
  assign opcode     = ir[OPC_LSB +: 3];
  assign rd0_addr   = (opcode == OP_BNZ) ? ir[RD_LSB +: 2] : ir[RS_LSB +: 2];
  assign rd1_addr   = ir[RT_LSB +: 2];
  assign wr_addr    = ir[RD_LSB +: 2];
  assign alu_op     = opcode;
  assign imm_data   = sext9(ir[IMM_LSB +: 4]);
  assign wb_sel     = (opcode == OP_LI);
  assign next_state = (opcode == OP_LI) ? ST_WRITEBACK : (opcode == OP_HALT) ? ST_HALT : ST_EXECUTE;
endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: fetch/decode/execute controller owning the PC and driving the register file
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int              PC_W    = 8,
  parameter logic [PC_W-1:0] BOOT_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [8:0]      instr_data,
  input  logic            instr_valid,
  output logic            instr_req,
  output logic [PC_W-1:0] pc,
  input  logic [8:0]      rd0_data,
  output logic            rf_rd_en,
  output logic            rf_wr_en,
  output logic [1:0]      rd0_addr,
  output logic [1:0]      rd1_addr,
  output logic [1:0]      wr_addr,
  output logic [2:0]      alu_op,
  output logic [8:0]      imm_data,
  output logic            wb_sel,
  output logic            halted
);
  state_t     state;
  state_t     dec_next;
  logic [8:0] ir;
  ctrl_fsm_instr_decode u_dec (
    .ir(ir), .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .wr_addr(wr_addr),
    .alu_op(alu_op), .imm_data(imm_data), .wb_sel(wb_sel), .next_state(dec_next)
  );
  assign rf_rd_en = (state == ST_DECODE);
  assign rf_wr_en = (state == ST_WRITEBACK);
  // instr_req is registered so it stays low while reset is held and rises one edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_FETCH;
      pc        <= BOOT_PC;
      ir        <= '0;
      instr_req <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          instr_req <= !instr_valid;
          if (instr_valid) begin
            ir    <= instr_data;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state  <= dec_next;
          halted <= (dec_next == ST_HALT);
        end
        ST_EXECUTE: begin
          if (ir[OPC_LSB +: 3] == OP_BNZ) begin
            pc        <= (rd0_data != '0) ? pc + PC_W'($signed(ir[IMM_LSB +: 4])) : pc + PC_W'(1);
            state     <= ST_FETCH;
            instr_req <= 1'b1;
          end else begin
            state <= ST_WRITEBACK;
          end
        end
        ST_WRITEBACK: begin
          pc        <= pc + PC_W'(1);
          state     <= ST_FETCH;
          instr_req <= 1'b1;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end
endmodule
